cgra_pe_ctx: RTL and testbench

Next-generation CGRA processing element with a local context memory of NUM_CTX configuration frames and a context sequencer. The sequencer steps through the frames for a programmed number of passes without external reconfiguration. Neighbour links use valid/ready handshakes. A registered, forkable output stage feeds the N/E/S/W neighbours and the local port. The block is a drop-in tile for the mesh fabric where loop bodies are modulo-scheduled into contexts.

---
 rtl/cgra_pe_ctx_if.sv | 39 +++
 rtl/cgra_pe_ctx.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_cgra_pe_ctx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_pe_ctx_if.sv
// ---------------------------------------------------------------------------
// cgra_pe_ctx_if
//   Neighbour link bundle of one CGRA processing element.
//
//   Handshake rule (applies to every lane of both directions): a word moves
//   in a cycle where its valid and ready are both high at the rising clock
//   edge. A producer holds valid and data stable until that happens, and
//   valid never depends on ready. Ready may depend on valid.
//
//   in_data   : packed N,E,S,W operands, N in [DATA_WIDTH-1:0]
//   in_valid  : per-direction operand valid (bit0 N .. bit3 W)
//   in_ready  : per-direction operand consumed this cycle
//   out_data  : registered result shared by every destination
//   out_valid : per-destination valid (bit0 N, E, S, W, bit4 local)
//   out_ready : per-destination ready
//
//   master : fabric side (drives operands, accepts results)
//   slave  : processing element side
// ---------------------------------------------------------------------------
interface cgra_pe_ctx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [4*DATA_WIDTH-1:0] in_data;
    logic [3:0]              in_valid;
    logic [3:0]              in_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [4:0]              out_valid;
    logic [4:0]              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/cgra_pe_ctx.sv
// ---------------------------------------------------------------------------
// cgra_pe_ctx
//   CGRA processing element with a local context memory and a sequencer that
//   steps through ctx_len frames for iter_cnt passes. Each fired context
//   reads up to two operands, computes one result and loads it into a
//   registered fork stage that feeds any subset of N/E/S/W/local.
//
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_cfg_we      : write i_cfg_data into context slot i_cfg_addr (idle only)
//   i_ctx_len     : contexts per pass (1..NUM_CTX), sampled at start
//   i_iter_cnt    : number of passes (0 = none), sampled at start
//   i_start       : start pulse, ignored while busy
//   o_busy        : sequencer running
//   o_done        : one-cycle pulse after the last context fired
//   o_state       : sequencer state (0 idle, 1 run)
//   o_pc          : current context index
//   link          : neighbour operand/result links
// ---------------------------------------------------------------------------
module cgra_pe_ctx #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_CTX    = 8,
    parameter int RF_DEPTH   = 8,
    parameter int LIF_LEAK   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_cfg_we,
    input  logic [$clog2(NUM_CTX)-1:0] i_cfg_addr,
    input  logic [63:0]                i_cfg_data,
    input  logic [$clog2(NUM_CTX):0]   i_ctx_len,
    input  logic [15:0]                i_iter_cnt,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [0:0]                 o_state,
    output logic [$clog2(NUM_CTX)-1:0] o_pc,
    cgra_pe_ctx_if.slave               link
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int CW = $clog2(NUM_CTX);
    localparam int RW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    // Internal arithmetic width: holds any acc +/- product without overflow.
    localparam int W  = ACC_WIDTH + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd3;
    localparam logic [5:0] OP_MAC   = 6'd4;
    localparam logic [5:0] OP_AND   = 6'd5;
    localparam logic [5:0] OP_OR    = 6'd6;
    localparam logic [5:0] OP_XOR   = 6'd7;
    localparam logic [5:0] OP_GT    = 6'd10;
    localparam logic [5:0] OP_LT    = 6'd11;
    localparam logic [5:0] OP_EQ    = 6'd12;
    localparam logic [5:0] OP_CLR   = 6'd15;
    localparam logic [5:0] OP_PASS0 = 6'd16;
    localparam logic [5:0] OP_LIF   = 6'd18;

    localparam logic signed [W-1:0] LEAK_W = W'(LIF_LEAK);

    // Only the low 41 frame bits carry meaning; the rest is reserved.
    logic [40:0]    r_ctx_mem [NUM_CTX];
    logic           w_unused_cfg;
    assign w_unused_cfg = ^i_cfg_data[63:41];

    logic [0:0]     r_state;
    logic [CW-1:0]  r_pc;
    logic [15:0]    r_pass;
    logic [CW:0]    r_ctx_len;
    logic [15:0]    r_iter;
    logic           r_done;
    logic [AW-1:0]  r_acc;
    logic           r_pred;
    logic [DW-1:0]  r_rf [RF_DEPTH];
    logic [4:0]     r_pending;
    logic [DW-1:0]  r_out_data;

    // Frame decode of the current context.
    logic [40:0]    w_frame;
    logic [5:0]     w_op;
    logic [3:0]     w_src0, w_src1, w_dst;
    logic [4:0]     w_route;
    logic           w_pred_en, w_pred_inv;
    logic [15:0]    w_imm;
    logic [DW-1:0]  w_imm_dw;

    assign w_frame    = r_ctx_mem[r_pc];
    assign w_op       = w_frame[5:0];
    assign w_src0     = w_frame[9:6];
    assign w_src1     = w_frame[13:10];
    assign w_dst      = w_frame[17:14];
    assign w_route    = w_frame[22:18];
    assign w_pred_en  = w_frame[23];
    assign w_pred_inv = w_frame[24];
    assign w_imm      = w_frame[40:25];
    assign w_imm_dw   = DW'($signed(w_imm));

    function automatic logic [DW-1:0] operand(input logic [3:0] sel);
        logic [DW-1:0] v;
        case (sel)
            4'd0:    v = link.in_data[0*DW +: DW];
            4'd1:    v = link.in_data[1*DW +: DW];
            4'd2:    v = link.in_data[2*DW +: DW];
            4'd3:    v = link.in_data[3*DW +: DW];
            4'd4:    v = w_imm_dw;
            4'd5:    v = r_acc[DW-1:0];
            default: begin
                if (32'(sel) >= 8 && 32'(sel) < 8 + RF_DEPTH)
                    v = r_rf[sel[RW-1:0]];
                else
                    v = '0;
            end
        endcase
        return v;
    endfunction

    function automatic logic [DW-1:0] sat_dw(input logic signed [W-1:0] v);
        logic signed [W-1:0] hi, lo;
        hi = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[DW-1:0];
        else if (v < lo) return lo[DW-1:0];
        else             return v[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] sat_acc(input logic signed [W-1:0] v);
        logic signed [W-1:0] hi, lo;
        hi = {{(W-AW+1){1'b0}}, {(AW-1){1'b1}}};
        lo = ~hi;
        if (v > hi)      return hi[AW-1:0];
        else if (v < lo) return lo[AW-1:0];
        else             return v[AW-1:0];
    endfunction

    // Handshake and sequencing.
    logic [3:0]  w_needed;
    logic        w_busy, w_exec, w_fire, w_last_ctx, w_last_pass;

    // A direction named by both sources is still a single token.
    always_comb begin
        w_needed = '0;
        for (int d = 0; d < 4; d++)
            w_needed[d] = (w_src0 == 4'(d)) || (w_src1 == 4'(d));
    end

    assign w_busy      = (r_state == S_RUN);
    assign w_exec      = !w_pred_en || (r_pred ^ w_pred_inv);
    // The stage may be reloaded in the cycle its last pending lane drains.
    assign w_fire      = w_busy && ((w_needed & ~link.in_valid) == 4'd0)
                         && ((r_pending & ~link.out_ready) == 5'd0);
    assign w_last_ctx  = ({1'b0, r_pc} == r_ctx_len - 1'b1);
    assign w_last_pass = (r_pass == r_iter - 16'd1);

    // Datapath.
    logic [DW-1:0]        w_a, w_b, w_res;
    logic signed [W-1:0]  w_a_x, w_b_x, w_prod_x, w_acc_x, w_lif_v;
    logic [AW-1:0]        w_mac, w_acc_n;
    logic                 w_has_res, w_acc_we, w_flag_we, w_flag_n;

    assign w_a      = operand(w_src0);
    assign w_b      = operand(w_src1);
    assign w_a_x    = {{(W-DW){w_a[DW-1]}}, w_a};
    assign w_b_x    = {{(W-DW){w_b[DW-1]}}, w_b};
    // Full product fits in 2*DW bits, well inside W.
    assign w_prod_x = w_a_x * w_b_x;
    assign w_acc_x  = {{2{r_acc[AW-1]}}, r_acc};
    assign w_mac    = sat_acc(w_acc_x + w_prod_x);
    assign w_lif_v  = w_acc_x + w_a_x - LEAK_W;

    always_comb begin
        w_res     = '0;
        w_has_res = 1'b1;
        w_acc_we  = 1'b0;
        w_acc_n   = '0;
        w_flag_we = 1'b0;
        w_flag_n  = 1'b0;
        case (w_op)
            OP_ADD:   w_res = sat_dw(w_a_x + w_b_x);
            OP_SUB:   w_res = sat_dw(w_a_x - w_b_x);
            OP_MUL:   w_res = sat_dw(w_prod_x);
            OP_MAC: begin
                w_acc_we = 1'b1;
                w_acc_n  = w_mac;
                w_res    = sat_dw({{2{w_mac[AW-1]}}, w_mac});
            end
            OP_AND:   w_res = w_a & w_b;
            OP_OR:    w_res = w_a | w_b;
            OP_XOR:   w_res = w_a ^ w_b;
            OP_GT, OP_LT, OP_EQ: begin
                w_flag_we = 1'b1;
                if (w_op == OP_GT)      w_flag_n = $signed(w_a) >  $signed(w_b);
                else if (w_op == OP_LT) w_flag_n = $signed(w_a) <  $signed(w_b);
                else                    w_flag_n = (w_a == w_b);
                w_res = {{(DW-1){1'b0}}, w_flag_n};
            end
            OP_CLR:   w_acc_we = 1'b1;
            OP_PASS0: w_res = w_a;
            OP_LIF: begin
                w_acc_we  = 1'b1;
                w_flag_we = 1'b1;
                if (w_lif_v >= w_b_x) begin
                    w_flag_n = 1'b1;
                    w_res    = {{(DW-1){1'b0}}, 1'b1};
                end else begin
                    w_acc_n  = sat_acc(w_lif_v);
                end
            end
            default:  w_has_res = 1'b0;
        endcase
    end

    logic       w_load;
    logic [4:0] w_pending_nx;
    assign w_load       = w_fire && w_exec && w_has_res;
    assign w_pending_nx = w_load ? w_route : (r_pending & ~link.out_ready);

    // Context memory: not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (i_cfg_we && !w_busy)
            r_ctx_mem[i_cfg_addr] <= i_cfg_data[40:0];
    end

    // Sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_pass    <= '0;
            r_ctx_len <= '0;
            r_iter    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_iter_cnt != 16'd0) begin
                            r_state   <= S_RUN;
                            r_pc      <= '0;
                            r_pass    <= '0;
                            r_ctx_len <= i_ctx_len;
                            r_iter    <= i_iter_cnt;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_fire) begin
                        if (w_last_ctx) begin
                            r_pc   <= '0;
                            r_pass <= r_pass + 16'd1;
                            if (w_last_pass) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Architectural state and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_pred     <= 1'b0;
            r_pending  <= '0;
            r_out_data <= '0;
            for (int i = 0; i < RF_DEPTH; i++)
                r_rf[i] <= '0;
        end else begin
            r_pending <= w_pending_nx;
            if (w_load) begin
                r_out_data <= w_res;
                if (32'(w_dst) < RF_DEPTH)
                    r_rf[w_dst[RW-1:0]] <= w_res;
                if (w_acc_we)
                    r_acc <= w_acc_n;
                if (w_flag_we)
                    r_pred <= w_flag_n;
            end
        end
    end

    assign link.in_ready  = w_fire ? w_needed : 4'd0;
    assign link.out_valid = r_pending;
    assign link.out_data  = r_out_data;
    assign o_busy         = w_busy;
    assign o_done         = r_done;
    assign o_state        = r_state;
    assign o_pc           = r_pc;
endmodule

// File: tb/tb_cgra_pe_ctx.sv
module tb_cgra_pe_ctx;
    logic        clk;
    logic        rst_n;
    logic        i_cfg_we;
    logic [2:0]  i_cfg_addr;
    logic [63:0] i_cfg_data;
    logic [3:0]  i_ctx_len;
    logic [15:0] i_iter_cnt;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [0:0]  o_state;
    logic [2:0]  o_pc;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, MAC = 6'd4, GT = 6'd10;
    localparam logic [5:0] CLR = 6'd15, PASS0 = 6'd16, LIF = 6'd18;
    localparam logic [3:0] S_N = 4'd0, S_IMM = 4'd4, S_ACC = 4'd5, S_ZERO = 4'd6;
    localparam logic [3:0] NO_DST = 4'd15;
    localparam logic [4:0] R_N = 5'b00001, R_E = 5'b00010, R_L = 5'b10000;

    cgra_pe_ctx_if #(.DATA_WIDTH(16)) link ();

    cgra_pe_ctx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_addr (i_cfg_addr),
        .i_cfg_data (i_cfg_data),
        .i_ctx_len  (i_ctx_len),
        .i_iter_cnt (i_iter_cnt),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state),
        .o_pc       (o_pc),
        .link       (link)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame(input logic [5:0] op, input logic [3:0] s0,
                                          input logic [3:0] s1, input logic [3:0] dst,
                                          input logic [4:0] route, input logic pe,
                                          input logic pi, input logic [15:0] imm);
        return {23'd0, imm, pi, pe, route, dst, s1, s0, op};
    endfunction

    task automatic set_ctx(input logic [2:0] addr, input logic [63:0] f);
        i_cfg_we   = 1'b1;
        i_cfg_addr = addr;
        i_cfg_data = f;
        tick();
        i_cfg_we   = 1'b0;
    endtask

    task automatic go(input logic [3:0] len, input logic [15:0] iters);
        i_ctx_len  = len;
        i_iter_cnt = iters;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic set_n(input logic [15:0] v, input logic vld);
        link.in_data  = {48'd0, v};
        link.in_valid = {3'b000, vld};
    endtask

    initial begin
        rst_n = 1'b0;
        i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
        i_ctx_len = '0; i_iter_cnt = '0; i_start = 1'b0;
        link.in_data = '0; link.in_valid = '0; link.out_ready = '0;
        tick(); tick();

        // Reset state
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_out_valid", 64'(link.out_valid), 64'd0);
        chk("rst_out_data", 64'(link.out_data), 64'd0);
        chk("rst_in_ready", 64'(link.in_ready), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        rst_n = 1'b1;
        tick();

        // ADD N + 5, three passes, result routed east, RF[0] written
        link.out_ready = 5'h1F;
        set_ctx(3'd0, frame(ADD, S_N, S_IMM, 4'd0, R_E, 1'b0, 1'b0, 16'd5));
        set_n(16'd10, 1'b1);
        go(4'd1, 16'd3);
        chk("add_busy", 64'(o_busy), 64'd1);
        chk("add_in_ready", 64'(link.in_ready), 64'h1);
        tick();
        chk("add_r0", 64'(link.out_data), 64'd15);
        chk("add_v0", 64'(link.out_valid), 64'(R_E));
        set_n(16'd20, 1'b1);
        tick();
        chk("add_r1", 64'(link.out_data), 64'd25);
        chk("add_done_early", 64'(o_done), 64'd0);
        set_n(16'd30, 1'b1);
        tick();
        chk("add_r2", 64'(link.out_data), 64'd35);
        chk("add_done", 64'(o_done), 64'd1);
        chk("add_busy_end", 64'(o_busy), 64'd0);
        set_n(16'd0, 1'b0);
        tick();
        chk("add_done_pulse", 64'(o_done), 64'd0);
        chk("add_drained", 64'(link.out_valid), 64'd0);

        // RF[0] read back through PASS0
        set_ctx(3'd0, frame(PASS0, 4'd8, S_ZERO, NO_DST, R_L, 1'b0, 1'b0, 16'd0));
        go(4'd1, 16'd1);
        tick();
        chk("rf0_value", 64'(link.out_data), 64'd35);
        chk("rf0_route", 64'(link.out_valid), 64'(R_L));

        // Saturation: ADD positive overflow, SUB negative overflow
        set_ctx(3'd0, frame(ADD, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'h0100));
        set_ctx(3'd1, frame(SUB, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'h0001));
        set_n(16'h7FF0, 1'b1);
        go(4'd2, 16'd1);
        tick();
        chk("sat_add", 64'(link.out_data), 64'h7FFF);
        set_n(16'h8000, 1'b1);
        tick();
        chk("sat_sub", 64'(link.out_data), 64'h8000);
        chk("sat_done", 64'(o_done), 64'd1);
        set_n(16'd0, 1'b0);

        // ACC_CLR then MAC 3*4 over two contexts, two passes
        set_ctx(3'd0, frame(CLR, S_ZERO, S_ZERO, NO_DST, R_L, 1'b0, 1'b0, 16'd0));
        go(4'd1, 16'd1);
        tick();
        chk("clr_result", 64'(link.out_data), 64'd0);
        chk("clr_valid", 64'(link.out_valid), 64'(R_L));
        set_ctx(3'd0, frame(MAC, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'd4));
        set_ctx(3'd1, frame(MAC, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'd4));
        set_n(16'd3, 1'b1);
        go(4'd2, 16'd2);
        tick();
        chk("mac_0", 64'(link.out_data), 64'd12);
        tick();
        chk("mac_1", 64'(link.out_data), 64'd24);
        tick();
        chk("mac_2", 64'(link.out_data), 64'd36);
        chk("mac_not_done", 64'(o_done), 64'd0);
        tick();
        chk("mac_3", 64'(link.out_data), 64'd48);
        chk("mac_done", 64'(o_done), 64'd1);
        set_n(16'd0, 1'b0);

        // Fork: N held not-ready while local drains; pc and inputs stall
        set_ctx(3'd0, frame(PASS0, S_N, S_ZERO, NO_DST, R_N | R_L, 1'b0, 1'b0, 16'd0));
        link.out_ready = R_L;
        set_n(16'h0011, 1'b1);
        go(4'd1, 16'd2);
        chk("fork_fire0", 64'(link.in_ready), 64'h1);
        tick();
        chk("fork_val0", 64'(link.out_valid), 64'(R_N | R_L));
        chk("fork_data0", 64'(link.out_data), 64'h11);
        chk("fork_stall0", 64'(link.in_ready), 64'h0);
        set_n(16'h0022, 1'b1);
        tick();
        chk("fork_local_drained", 64'(link.out_valid), 64'(R_N));
        chk("fork_stall1", 64'(link.in_ready), 64'h0);
        tick();
        chk("fork_n_held", 64'(link.out_valid), 64'(R_N));
        chk("fork_stall2", 64'(link.in_ready), 64'h0);
        chk("fork_busy", 64'(o_busy), 64'd1);
        link.out_ready = 5'h1F;
        #1;
        chk("fork_reload_same_cycle", 64'(link.in_ready), 64'h1);
        tick();
        chk("fork_data1", 64'(link.out_data), 64'h22);
        chk("fork_val1", 64'(link.out_valid), 64'(R_N | R_L));
        chk("fork_done", 64'(o_done), 64'd1);
        set_n(16'd0, 1'b0);
        tick();
        chk("fork_empty", 64'(link.out_valid), 64'd0);

        // Predicate: GT sets flag, inverted-predicated PASS0 is squashed
        set_ctx(3'd0, frame(GT, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'd3));
        set_ctx(3'd1, frame(PASS0, S_N, S_ZERO, 4'd1, R_L, 1'b1, 1'b1, 16'd0));
        set_n(16'd5, 1'b1);
        go(4'd2, 16'd1);
        chk("pred_gt_consume", 64'(link.in_ready), 64'h1);
        tick();
        chk("pred_gt_result", 64'(link.out_data), 64'd1);
        chk("pred_pc", 64'(o_pc), 64'd1);
        chk("pred_skip_consume", 64'(link.in_ready), 64'h1);
        tick();
        chk("pred_no_output", 64'(link.out_valid), 64'd0);
        chk("pred_data_kept", 64'(link.out_data), 64'd1);
        chk("pred_done", 64'(o_done), 64'd1);
        set_n(16'd0, 1'b0);
        set_ctx(3'd0, frame(PASS0, 4'd9, S_ZERO, NO_DST, R_L, 1'b0, 1'b0, 16'd0));
        go(4'd1, 16'd1);
        tick();
        chk("pred_rf1_unwritten", 64'(link.out_data), 64'd0);

        // LIF: leak 10, threshold 100, input 40
        set_ctx(3'd0, frame(CLR, S_ZERO, S_ZERO, NO_DST, 5'd0, 1'b0, 1'b0, 16'd0));
        for (int c = 1; c <= 4; c++)
            set_ctx(3'(c), frame(LIF, S_N, S_IMM, NO_DST, R_L, 1'b0, 1'b0, 16'd100));
        set_n(16'd40, 1'b1);
        go(4'd5, 16'd1);
        chk("lif_clr_no_input", 64'(link.in_ready), 64'h0);
        tick();
        chk("lif_clr_no_output", 64'(link.out_valid), 64'd0);
        tick();
        chk("lif_v30", 64'({link.out_valid, link.out_data}), 64'({R_L, 16'd0}));
        tick();
        chk("lif_v60", 64'({link.out_valid, link.out_data}), 64'({R_L, 16'd0}));
        tick();
        chk("lif_v90", 64'({link.out_valid, link.out_data}), 64'({R_L, 16'd0}));
        tick();
        chk("lif_spike", 64'({link.out_valid, link.out_data}), 64'({R_L, 16'd1}));
        chk("lif_done", 64'(o_done), 64'd1);
        set_n(16'd0, 1'b0);
        set_ctx(3'd0, frame(PASS0, S_ACC, S_ZERO, NO_DST, R_L, 1'b0, 1'b0, 16'd0));
        go(4'd1, 16'd1);
        tick();
        chk("lif_acc_zero", 64'(link.out_data), 64'd0);

        // Zero passes: done next cycle, never busy
        go(4'd1, 16'd0);
        chk("zero_iter_done", 64'(o_done), 64'd1);
        chk("zero_iter_busy", 64'(o_busy), 64'd0);
        tick();
        chk("zero_iter_pulse", 64'(o_done), 64'd0);

        // Mid-run reset drops pending output immediately
        set_ctx(3'd0, frame(PASS0, S_N, S_ZERO, NO_DST, R_N | R_L, 1'b0, 1'b0, 16'd0));
        link.out_ready = 5'd0;
        set_n(16'h0055, 1'b1);
        go(4'd1, 16'd5);
        tick();
        chk("mid_pending", 64'(link.out_valid), 64'(R_N | R_L));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_out_valid", 64'(link.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(link.in_ready), 64'd0);
        chk("mid_rst_out_data", 64'(link.out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        set_n(16'd0, 1'b0);
        tick();
        chk("post_rst_state", 64'(o_state), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
